// File: rtl/jpeg_pkg.sv
// Constants and FSM state type shared by the JPEG output path.
// The EOI states only drive logic when JPEG_BYTE_STUFFER_EOI_EN is defined.
package jpeg_pkg;

    localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
    localparam logic [7:0] JPEG_EOI_CODE      = 8'hD9;

    typedef enum logic [1:0] {
        ST_PASS   = 2'd0,
        ST_STUFF  = 2'd1,
        ST_EOI_FF = 2'd2,
        ST_EOI_D9 = 2'd3
    } stuffer_state_t;

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// Inserts 0x00 after every 0xFF in the entropy-coded stream and counts emitted bytes.
// Define JPEG_BYTE_STUFFER_EOI_EN to append the EOI marker (FF D9) at frame end.
module jpeg_byte_stuffer
    import jpeg_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [7:0]           s_tdata,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic                 s_tready,
    output logic [7:0]           m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic [CNT_WIDTH-1:0] o_byte_count,
    output logic                 o_busy
);

    stuffer_state_t       state_q, state_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 tlast_q, tlast_d;
    logic                 last_q, last_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic free;
    logic s_hs;
    logic m_hs;

    // The single output register can take a new byte whenever it is empty or draining.
    assign free     = !valid_q || m_tready;
    assign s_tready = n_rst && free && (state_q == ST_PASS);
    assign s_hs     = s_tvalid && s_tready;
    assign m_hs     = valid_q && m_tready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        tlast_d = tlast_q;
        last_d  = last_q;
        case (state_q)
            ST_PASS: begin
                if (s_hs) begin
                    data_d  = s_tdata;
                    valid_d = 1'b1;
                    tlast_d = 1'b0;
                    last_d  = s_tlast;
                    if (s_tdata == JPEG_MARKER_PREFIX) begin
                        state_d = ST_STUFF;
                    end else if (s_tlast) begin
`ifdef JPEG_BYTE_STUFFER_EOI_EN
                        state_d = ST_EOI_FF;
`else
                        tlast_d = 1'b1;
`endif
                    end
                end else if (free) begin
                    valid_d = 1'b0;
                    tlast_d = 1'b0;
                end
            end
            ST_STUFF: begin
                if (free) begin
                    data_d  = JPEG_STUFF_BYTE;
                    valid_d = 1'b1;
                    tlast_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = ST_PASS;
                    if (last_q) begin
`ifdef JPEG_BYTE_STUFFER_EOI_EN
                        state_d = ST_EOI_FF;
`else
                        tlast_d = 1'b1;
`endif
                    end
                end
            end
`ifdef JPEG_BYTE_STUFFER_EOI_EN
            // Marker prefix of EOI goes out raw; it must not be stuffed.
            ST_EOI_FF: begin
                if (free) begin
                    data_d  = JPEG_MARKER_PREFIX;
                    valid_d = 1'b1;
                    tlast_d = 1'b0;
                    state_d = ST_EOI_D9;
                end
            end
            ST_EOI_D9: begin
                if (free) begin
                    data_d  = JPEG_EOI_CODE;
                    valid_d = 1'b1;
                    tlast_d = 1'b1;
                    state_d = ST_PASS;
                end
            end
`endif
            default: begin
                state_d = ST_PASS;
            end
        endcase
    end

    // Count restarts on the first byte after a completed frame so the old total stays visible.
    always_comb begin
        count_d = count_q;
        done_d  = done_q;
        busy_d  = busy_q;
        if (m_hs) begin
            if (done_q) begin
                count_d = CNT_WIDTH'(1);
            end else if (count_q != '1) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
            done_d = tlast_q;
            if (tlast_q) begin
                busy_d = 1'b0;
            end
        end
        if (s_hs) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= ST_PASS;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            tlast_q <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            tlast_q <= tlast_d;
            last_q  <= last_d;
            count_q <= count_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign m_tdata      = data_q;
    assign m_tvalid     = valid_q;
    assign m_tlast      = tlast_q;
    assign o_byte_count = count_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Scoreboard bench for jpeg_byte_stuffer; follows JPEG_BYTE_STUFFER_EOI_EN like the DUT.
module tb_jpeg_byte_stuffer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b0;
    logic [31:0] o_byte_count;
    logic        o_busy;

`ifdef JPEG_BYTE_STUFFER_EOI_EN
    localparam bit EOI_ON = 1'b1;
`else
    localparam bit EOI_ON = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t        expQ[$];
    logic [7:0]  stimQ[$];
    int          errors = 0;
    int          checks = 0;
    int          frameLen = 0;
    bit          pendFfChk = 0;
    bit          pendBusyChk = 0;
    logic [31:0] expCnt = 0;
    bit          cntDone = 0;
    bit          holdValid = 0;
    logic [7:0]  holdData = 8'h00;
    logic        holdLast = 1'b0;

    jpeg_byte_stuffer #(.CNT_WIDTH(32)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tlast      (s_tlast),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tlast      (m_tlast),
        .m_tready     (m_tready),
        .o_byte_count (o_byte_count),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting for the DUT at %0t", name, $time);
    endtask

    // Reference rule: each byte maps to itself, plus 00 if it is FF; frame end adds FF D9 when enabled.
    task automatic pushExpansion(input logic [7:0] b, input bit last);
        if (b == 8'hFF) begin
            expQ.push_back(exp_t'{8'hFF, 1'b0});
            expQ.push_back(exp_t'{8'h00, last && !EOI_ON});
            frameLen += 2;
        end else begin
            expQ.push_back(exp_t'{b, last && !EOI_ON});
            frameLen += 1;
        end
        if (last && EOI_ON) begin
            expQ.push_back(exp_t'{8'hFF, 1'b0});
            expQ.push_back(exp_t'{8'hD9, 1'b1});
            frameLen += 2;
        end
    endtask

    task automatic cycleDrive(input bit v, input logic [7:0] d, input bit l, input bit r, output bit acc);
        @(negedge clk);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = r;
        #4;
        if (pendFfChk) checkOutput("s_tready_after_ff", 32'(s_tready), 32'd0);
        if (pendBusyChk) checkOutput("busy_after_accept", 32'(o_busy), 32'd1);
        pendFfChk   = 0;
        pendBusyChk = 0;
        acc = v && s_tready;
        if (acc) begin
            pushExpansion(d, l);
            pendFfChk   = (d == 8'hFF);
            pendBusyChk = 1;
        end
    endtask

    task automatic applyStimulus(input bit randomMode);
        bit acc;
        bit r;
        int tries;
        frameLen = 0;
        for (int i = 0; i < stimQ.size(); i++) begin
            acc   = 0;
            tries = 0;
            while (!acc) begin
                r = randomMode ? 1'($urandom_range(0, 1)) : 1'b1;
                if (randomMode && $urandom_range(0, 3) == 0)
                    cycleDrive(1'b0, 8'($urandom), 1'b0, r, acc);
                else
                    cycleDrive(1'b1, stimQ[i], (i == stimQ.size() - 1), r, acc);
                tries++;
                if (!acc && tries > 2000) begin
                    reportTimeout("input_accept");
                    return;
                end
            end
        end
    endtask

    task automatic waitDrain(input string name);
        bit acc;
        bit drained = 0;
        for (int i = 0; i < 500 && !drained; i++) begin
            cycleDrive(1'b0, 8'h00, 1'b0, 1'b1, acc);
            @(posedge clk);
            #1;
            drained = (expQ.size() == 0) && !m_tvalid;
        end
        if (!drained) reportTimeout({name, "_drain"});
        checkOutput({name, "_busy_idle"}, 32'(o_busy), 32'd0);
        checkOutput({name, "_frame_count"}, o_byte_count, 32'(frameLen));
    endtask

    // Monitor: pops the scoreboard on every output handshake and tracks the byte counter.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!n_rst) begin
                expQ.delete();
                expCnt    = 0;
                cntDone   = 0;
                holdValid = 0;
            end else begin
                checkOutput("byte_count", o_byte_count, expCnt);
                if (holdValid) begin
                    checkOutput("hold_valid", 32'(m_tvalid), 32'd1);
                    checkOutput("hold_data", 32'(m_tdata), 32'(holdData));
                    checkOutput("hold_last", 32'(m_tlast), 32'(holdLast));
                end
                holdValid = m_tvalid && !m_tready;
                holdData  = m_tdata;
                holdLast  = m_tlast;
                if (m_tvalid && m_tready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_output: got 0x%0h, expected nothing at %0t", m_tdata, $time);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("out_data", 32'(m_tdata), 32'(e.data));
                        checkOutput("out_last", 32'(m_tlast), 32'(e.last));
                    end
                    if (cntDone) expCnt = 1;
                    else expCnt = expCnt + 1;
                    cntDone = m_tlast;
                end
            end
        end
    end

    initial begin
        bit acc;
        $display("[TB] jpeg_byte_stuffer bench, EOI enabled = %0d", EOI_ON);
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        checkOutput("s_tready_in_reset", 32'(s_tready), 32'd0);
        checkOutput("m_tvalid_in_reset", 32'(m_tvalid), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        #4;
        checkOutput("rst_s_tready", 32'(s_tready), 32'd1);
        checkOutput("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("rst_m_tlast", 32'(m_tlast), 32'd0);
        checkOutput("rst_m_tdata", 32'(m_tdata), 32'd0);
        checkOutput("rst_count", o_byte_count, 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);

        stimQ.delete();
        stimQ.push_back(8'h12);
        stimQ.push_back(8'h34);
        applyStimulus(1'b0);
        waitDrain("plain");

        stimQ.delete();
        stimQ.push_back(8'hFF);
        stimQ.push_back(8'hFF);
        stimQ.push_back(8'h55);
        applyStimulus(1'b0);
        waitDrain("double_ff");

        stimQ.delete();
        stimQ.push_back(8'hFF);
        applyStimulus(1'b0);
        waitDrain("single_ff_last");

        stimQ.delete();
        for (int i = 0; i < 256; i++)
            stimQ.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
        applyStimulus(1'b1);
        waitDrain("random");

        // Park the FSM in STUFF, then reset for one cycle.
        frameLen = 0;
        cycleDrive(1'b1, 8'hFF, 1'b0, 1'b1, acc);
        checkOutput("accept_ff_before_reset", 32'(acc), 32'd1);
        @(negedge clk);
        n_rst    = 1'b0;
        s_tvalid = 1'b0;
        pendFfChk   = 0;
        pendBusyChk = 0;
        @(negedge clk);
        n_rst = 1'b1;
        #4;
        checkOutput("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("midrst_count", o_byte_count, 32'd0);
        checkOutput("midrst_s_tready", 32'(s_tready), 32'd1);
        checkOutput("midrst_busy", 32'(o_busy), 32'd0);
        stimQ.delete();
        stimQ.push_back(8'hAB);
        applyStimulus(1'b0);
        waitDrain("after_reset");

        stimQ.delete();
        for (int i = 0; i < 3; i++) stimQ.push_back(8'($urandom_range(0, 254)));
        applyStimulus(1'b0);
        waitDrain("frame3");
        stimQ.delete();
        for (int i = 0; i < 5; i++) stimQ.push_back(8'($urandom_range(0, 254)));
        applyStimulus(1'b0);
        waitDrain("frame5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
